// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and default constants for the multiplexed 7-segment scan controller.
package seg7_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int DEF_N_DIGITS  = 4;
    localparam int DEF_DIV       = 1000;
    localparam int DEF_BLANK_CYC = 8;

endpackage

// File: rtl/bin_segment7.sv
// Hex nibble to 7-segment decoder; out = {g,f,e,d,c,b,a}, active-high segments.
module bin_segment7 (
    input  logic [3:0] bin,
    output logic [6:0] out
);

    always_comb begin
        // NOTE: the default assignment ahead of the case keeps this purely combinational (no latch).
        out = 7'h00;
        case (bin)
            4'h0: out = 7'h3F;
            4'h1: out = 7'h06;
            4'h2: out = 7'h5B;
            4'h3: out = 7'h4F;
            4'h4: out = 7'h66;
            4'h5: out = 7'h6D;
            4'h6: out = 7'h7D;
            4'h7: out = 7'h07;
            4'h8: out = 7'h7F;
            4'h9: out = 7'h6F;
            4'hA: out = 7'h77;
            4'hB: out = 7'h7C;
            4'hC: out = 7'h39;
            4'hD: out = 7'h5E;
            4'hE: out = 7'h79;
            4'hF: out = 7'h71;
            default: out = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with per-frame value shadowing and dead-time blanking.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS  = DEF_N_DIGITS,
    parameter int DIV       = DEF_DIV,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        val_we,
    input  logic [4*N_DIGITS-1:0]       val,
    output logic [N_DIGITS-1:0]         an,
    output logic [6:0]                  seg,
    output logic [$clog2(N_DIGITS)-1:0] dig_idx,
    output logic                        frame_done
);

    localparam int IDX_W   = $clog2(N_DIGITS);
    // One counter serves both DRIVE and BLANK, so it must also hold BLANK_CYC.
    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] DRV_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLK_END  = CNT_W'(BLANK_CYC - 1);

    scan_state_t               state;
    logic [CNT_W-1:0]          cnt;
    logic [4*N_DIGITS-1:0]     pend;
    logic [4*N_DIGITS-1:0]     shadow;
    logic [4*N_DIGITS-1:0]     load_src;
    logic                      drv_last;

    // A strobe landing on the boundary edge bypasses the pending register.
    assign load_src = val_we ? val : pend;
    assign drv_last = (cnt == DRV_END);

`ifdef SEG7_LZB_EN
    function automatic logic [N_DIGITS-1:0] drive_an(input logic [IDX_W-1:0] i,
                                                     input logic [4*N_DIGITS-1:0] sh);
        logic [N_DIGITS-1:0] m;
        m    = '1;
        m[i] = 1'b0;
        if (i != '0 && (sh >> (4 * i)) == '0) m = '1;
        return m;
    endfunction
`else
    function automatic logic [N_DIGITS-1:0] drive_an(input logic [IDX_W-1:0] i);
        logic [N_DIGITS-1:0] m;
        m    = '1;
        m[i] = 1'b0;
        return m;
    endfunction
`endif

`ifdef SEG7_LZB_EN
    `define SEG7_AN(i, sh) drive_an(i, sh)
`else
    `define SEG7_AN(i, sh) drive_an(i)
`endif

    // NOTE: pend and shadow are plain registers, not a memory, so they take the async reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dig_idx    <= '0;
            an         <= '1;
            frame_done <= 1'b0;
            pend       <= '0;
            shadow     <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads the pre-edge state.
            frame_done <= 1'b0;
            if (val_we) pend <= val;

            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                dig_idx <= '0;
                an      <= '1;
            end else begin
                case (state)
                    IDLE: begin
                        shadow  <= load_src;
                        dig_idx <= '0;
                        cnt     <= '0;
                        if (BLANK_CYC == 0) begin
                            state <= DRIVE;
                            an    <= `SEG7_AN('0, load_src);
                        end else begin
                            state <= BLANK;
                            an    <= '1;
                        end
                    end

                    BLANK: begin
                        if (cnt == BLK_END) begin
                            state      <= DRIVE;
                            cnt        <= '0;
                            an         <= `SEG7_AN(dig_idx, shadow);
                            frame_done <= (DIV == 1) && (dig_idx == LAST_IDX);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    DRIVE: begin
                        if (drv_last) begin
                            cnt <= '0;
                            if (BLANK_CYC == 0) begin
                                state <= DRIVE;
                                if (dig_idx == LAST_IDX) begin
                                    dig_idx <= '0;
                                    shadow  <= load_src;
                                    an      <= `SEG7_AN('0, load_src);
                                end else begin
                                    dig_idx    <= dig_idx + 1'b1;
                                    an         <= `SEG7_AN(dig_idx + 1'b1, shadow);
                                    frame_done <= (DIV == 1) && (dig_idx + 1'b1 == LAST_IDX);
                                end
                            end else begin
                                state <= BLANK;
                                an    <= '1;
                                if (dig_idx == LAST_IDX) begin
                                    dig_idx <= '0;
                                    shadow  <= load_src;
                                end else begin
                                    dig_idx <= dig_idx + 1'b1;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            // Registered pulse lands on the final DRIVE cycle of the frame.
                            frame_done <= (dig_idx == LAST_IDX) &&
                                          (32'(cnt) + 32'd2 == 32'(DIV));
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        dig_idx <= '0;
                        an      <= '1;
                    end
                endcase
            end
        end
    end

`undef SEG7_AN

    bin_segment7 u_dec (
        .bin (shadow[{dig_idx, 2'b00} +: 4]),
        .out (seg)
    );

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N_DIGITS=4, DIV=4, BLANK_CYC=2 (24-cycle frame).
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        val_we;
    logic [15:0] val;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  dig_idx;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    logic [6:0] seg_tbl [16];

    seg7_scan_ctrl #(.N_DIGITS(4), .DIV(4), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .val_we     (val_we),
        .val        (val),
        .an         (an),
        .seg        (seg),
        .dig_idx    (dig_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one 24-cycle frame: positions 0-1 of each 6-cycle slot are dead time,
    // 2-5 drive the slot's digit. Optionally strobes inj_val at position inj_p,
    // and returns without advancing after checking position last_p.
    task automatic check_frame(input string name, input logic [15:0] v, input logic [3:0] lit,
                               input int inj_p, input logic [15:0] inj_val, input int last_p);
        int         slot;
        logic [3:0] exp_an;
        logic [3:0] nib;
        for (int p = 0; p < 24; p++) begin
            slot   = p / 6;
            exp_an = 4'b1111;
            if ((p % 6) >= 2 && lit[slot]) exp_an[slot] = 1'b0;
            nib = v[slot*4 +: 4];
            check($sformatf("%s.an@%0d", name, p), 32'(an), 32'(exp_an));
            check($sformatf("%s.idx@%0d", name, p), 32'(dig_idx), 32'(slot));
            check($sformatf("%s.fd@%0d", name, p), 32'(frame_done), 32'(p == 23));
            if ((p % 6) >= 2)
                check($sformatf("%s.seg@%0d", name, p), 32'(seg), 32'(seg_tbl[nib]));
            if (p == last_p) return;
            if (p == inj_p) begin
                val_we = 1'b1;
                val    = inj_val;
            end else begin
                val_we = 1'b0;
            end
            step();
        end
        val_we = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, ".an"}, 32'(an), 32'hF);
        check({name, ".idx"}, 32'(dig_idx), 32'd0);
        check({name, ".fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        logic [3:0] lzb_mask_50;
        logic [3:0] lzb_mask_00;
`ifdef SEG7_LZB_EN
        lzb_mask_50 = 4'b0011;
        lzb_mask_00 = 4'b0001;
`else
        lzb_mask_50 = 4'b1111;
        lzb_mask_00 = 4'b1111;
`endif
        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        rst_n  = 1'b0;
        en     = 1'b0;
        val_we = 1'b0;
        val    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check_idle("idle_en0");

        // Load 1234 while idle, then enable: scan starts with BLANK on digit 0.
        val_we = 1'b1;
        val    = 16'h1234;
        step();
        val_we = 1'b0;
        en     = 1'b1;
        step();
        check_frame("f1234", 16'h1234, 4'b1111, -1, '0, 99);
        // Mid-frame write must not tear the current frame.
        check_frame("ftear", 16'h1234, 4'b1111, 9, 16'hABCD, 99);
        // Strobe on the frame_done cycle takes the boundary bypass.
        check_frame("fabcd", 16'hABCD, 4'b1111, 23, 16'h5555, 99);
        // Strobe just after the boundary waits a whole frame.
        check_frame("f5555", 16'h5555, 4'b1111, 0, 16'h9876, 99);
        // Disable during DRIVE of digit 2.
        check_frame("fdis", 16'h9876, 4'b1111, -1, '0, 15);
        en = 1'b0;
        step();
        check_idle("dis1");
        step();
        check_idle("dis2");
        en = 1'b1;
        step();
        check_frame("frestart", 16'h9876, 4'b1111, 7, 16'h0050, 99);
        check_frame("f0050", 16'h0050, lzb_mask_50, 20, 16'h0000, 99);
        check_frame("f0000", 16'h0000, lzb_mask_00, 5, 16'h1234, 99);
        // Async reset on the last DRIVE cycle, while frame_done is high.
        check_frame("frst", 16'h1234, 4'b1111, -1, '0, 23);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst.an", 32'(an), 32'hF);
        check("async_rst.fd", 32'(frame_done), 32'd0);
        check("async_rst.idx", 32'(dig_idx), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
